// File: rtl/reg_port_arbiter_if.sv
// Register-port bundle: I2C slave strobes, local req/gnt requester and the shared RAM port.
interface reg_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_wdata;
  logic          i2c_wr;
  logic          i2c_rd;
  logic [DW-1:0] i2c_rdata;
  logic          loc_req;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [DW-1:0] loc_wdata;
  logic          loc_gnt;
  logic          loc_rvalid;
  logic [DW-1:0] loc_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          ovf_err;

  modport slave (
    input  i2c_addr, i2c_wdata, i2c_wr, i2c_rd,
    output i2c_rdata,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output loc_gnt, loc_rvalid, loc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output ovf_err
  );

  modport master (
    output i2c_addr, i2c_wdata, i2c_wr, i2c_rd,
    input  i2c_rdata,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  loc_gnt, loc_rvalid, loc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  ovf_err
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Shares one sync single-port register RAM between a non-stallable I2C strobe port
// (buffered writes, shadow read data) and a local req/gnt requester.
module reg_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t        r_state;
  logic          r_tag_loc;
  logic          r_wr_pend;
  logic          r_rf_pend;
  logic          r_ovf;
  logic [AW-1:0] r_wb_addr;
  logic [DW-1:0] r_wb_data;
  logic [AW-1:0] r_i2c_addr;
  logic [AW-1:0] r_rf_addr;
  logic [DW-1:0] r_i2c_rdata;

  logic          w_idle;
  logic          w_rd_done;
  logic          w_rf_req;
  logic          w_wr_go;
  logic          w_rf_go;
  logic          w_loc_go;
  logic          w_loc_hit;

  // Access decode is combinational so a grant and its RAM access share one cycle;
  // gating with rst_n keeps every output quiet while reset is held.
  assign w_idle    = rst_n && (r_state == IDLE);
  assign w_rd_done = rst_n && (r_state == RD_WAIT);
  // A stale shadow address requests a refresh at once, not a cycle later via r_rf_pend.
  assign w_rf_req  = r_rf_pend || (r_i2c_addr != r_rf_addr);
  assign w_wr_go   = w_idle && r_wr_pend;
  assign w_rf_go   = w_idle && !r_wr_pend && w_rf_req;
  assign w_loc_go  = w_idle && !r_wr_pend && !w_rf_req && bus.loc_req;
  assign w_loc_hit = w_loc_go && bus.loc_we && (bus.loc_addr == bus.i2c_addr);

  assign bus.mem_en    = w_wr_go || w_rf_go || w_loc_go;
  assign bus.mem_we    = w_wr_go || (w_loc_go && bus.loc_we);
  assign bus.mem_addr  = w_wr_go  ? r_wb_addr  :
                         w_rf_go  ? r_i2c_addr :
                         w_loc_go ? bus.loc_addr : '0;
  assign bus.mem_wdata = w_wr_go  ? r_wb_data  :
                         (w_loc_go && bus.loc_we) ? bus.loc_wdata : '0;

  assign bus.loc_gnt    = w_loc_go;
  assign bus.loc_rvalid = w_rd_done && r_tag_loc;
  assign bus.loc_rdata  = bus.loc_rvalid ? bus.mem_rdata : '0;
  assign bus.i2c_rdata  = r_i2c_rdata;
  assign bus.ovf_err    = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tag_loc   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rf_pend   <= 1'b1;
      r_ovf       <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_i2c_addr  <= '0;
      r_rf_addr   <= '0;
      r_i2c_rdata <= '0;
    end else begin
      r_i2c_addr <= bus.i2c_addr;
      if (bus.i2c_wr) begin
        r_wb_addr <= bus.i2c_addr;
        r_wb_data <= bus.i2c_wdata;
        if (r_wr_pend) r_ovf <= 1'b1;
      end
      r_wr_pend <= bus.i2c_wr || (r_wr_pend && !w_wr_go);
      r_rf_pend <= (r_rf_pend && !w_rf_go) || bus.i2c_rd || w_wr_go || w_loc_hit;

      case (r_state)
        IDLE: begin
          if (w_rf_go) begin
            r_state   <= RD_WAIT;
            r_tag_loc <= 1'b0;
            r_rf_addr <= r_i2c_addr;
          end else if (w_loc_go && !bus.loc_we) begin
            r_state   <= RD_WAIT;
            r_tag_loc <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (!r_tag_loc) r_i2c_rdata <= bus.mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter: behavioural sync RAM, write/read scoreboards.
module tb_reg_port_arbiter;

  logic clk;
  logic rst_n;
  int   nchk;
  int   npass;
  int   gnt_cnt;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  ram [256];

  reg_port_arbiter_if #(.AW(8), .DW(8)) bus();

  reg_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync single-port RAM; contents reload (all 0, [0]=5A) whenever reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[0] <= 8'h5A;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      chk("wr_expected", wq.size() != 0, 1);
      if (wq.size() != 0) chk("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, wq.pop_front());
    end
    if (bus.loc_rvalid) begin
      chk("rvalid_expected", rq.size() != 0, 1);
      if (rq.size() != 0) chk("loc_rdata", bus.loc_rdata, rq.pop_front());
    end
    if (bus.loc_gnt) gnt_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.loc_gnt && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.loc_gnt, 1);
    @(posedge clk);
    #1;
    bus.loc_req = 1'b0;
  endtask

  initial begin
    int n;
    nchk = 0; npass = 0; gnt_cnt = 0;
    rst_n = 1'b0;
    bus.i2c_addr = '0; bus.i2c_wdata = '0; bus.i2c_wr = 1'b0; bus.i2c_rd = 1'b0;
    bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_wdata = '0;
    bus.mem_rdata = '0;
    cyc(3);
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_loc_gnt", bus.loc_gnt, 0);
    chk("rst_rvalid", bus.loc_rvalid, 0);
    chk("rst_i2c_rdata", bus.i2c_rdata, 0);
    chk("rst_ovf", bus.ovf_err, 0);

    // Refresh after reset reads address 0
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_read", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h00});
    n = 0;
    while (bus.i2c_rdata !== 8'h5A && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_rdata", bus.i2c_rdata, 8'h5A);

    // Single I2C write while idle
    cyc(1);
    bus.i2c_addr = 8'h10; bus.i2c_wdata = 8'hA5; bus.i2c_wr = 1'b1;
    wq.push_back({8'h10, 8'hA5});
    cyc(1);
    bus.i2c_wr = 1'b0;
    cyc(1);
    chk("wr10_latency", wq.size(), 0);
    cyc(3);
    chk("wr10_rdata", bus.i2c_rdata, 8'hA5);
    chk("wr10_ovf", bus.ovf_err, 0);

    // Simultaneous local write and I2C write
    bus.i2c_addr = 8'h21; bus.i2c_wdata = 8'h44; bus.i2c_wr = 1'b1;
    bus.loc_req = 1'b1; bus.loc_we = 1'b1; bus.loc_addr = 8'h20; bus.loc_wdata = 8'h33;
    wq.push_back({8'h20, 8'h33});
    wq.push_back({8'h21, 8'h44});
    wait_gnt("sim_gnt");
    bus.i2c_wr = 1'b0;
    cyc(3);
    chk("sim_gnt_once", gnt_cnt, 1);
    chk("sim_writes_done", wq.size(), 0);
    chk("sim_ram20", ram[8'h20], 8'h33);
    chk("sim_ram21", ram[8'h21], 8'h44);
    chk("sim_rdata21", bus.i2c_rdata, 8'h44);

    // Local read vs I2C address change: refresh wins
    bus.i2c_addr = 8'h10;
    cyc(1);
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h21;
    rq.push_back(8'h44);
    @(negedge clk);
    chk("rf_first_gnt", bus.loc_gnt, 0);
    chk("rf_first_addr", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h10});
    wait_gnt("rd21_gnt");
    cyc(3);
    chk("rd21_done", rq.size(), 0);
    chk("rd21_shadow", bus.i2c_rdata, 8'hA5);

    // Local write to the current I2C address updates the shadow
    bus.i2c_addr = 8'h21;
    cyc(5);
    chk("back21_rdata", bus.i2c_rdata, 8'h44);
    bus.loc_req = 1'b1; bus.loc_we = 1'b1; bus.loc_addr = 8'h21; bus.loc_wdata = 8'h77;
    wq.push_back({8'h21, 8'h77});
    wait_gnt("lw21_gnt");
    cyc(2);
    chk("lw21_shadow", bus.i2c_rdata, 8'h77);

    // Back-to-back I2C writes while a local read sits in RD_WAIT
    cyc(2);
    bus.i2c_addr = 8'h30; bus.i2c_wdata = 8'h11; bus.i2c_wr = 1'b1;
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h20;
    rq.push_back(8'h33);
    @(negedge clk);
    chk("ovf_loc_gnt", bus.loc_gnt, 1);
    cyc(1);
    bus.loc_req = 1'b0; bus.i2c_wdata = 8'h22;
    wq.push_back({8'h30, 8'h22});
    cyc(1);
    bus.i2c_wr = 1'b0;
    cyc(5);
    chk("ovf_flag", bus.ovf_err, 1);
    chk("ovf_writes_done", wq.size(), 0);
    chk("ovf_ram30", ram[8'h30], 8'h22);
    chk("ovf_rd_done", rq.size(), 0);
    chk("ovf_shadow", bus.i2c_rdata, 8'h22);
    chk("gnt_total", gnt_cnt, 4);

    // Reset while a local read is in flight
    bus.i2c_addr = 8'h00;
    cyc(5);
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h20;
    @(negedge clk);
    chk("rst_mid_gnt", bus.loc_gnt, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.loc_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", bus.loc_rvalid, 0);
    cyc(2);
    chk("rst_mid_ovf", bus.ovf_err, 0);
    chk("rst_mid_rdata", bus.i2c_rdata, 0);
    chk("rst_mid_mem_en", bus.mem_en, 0);
    rst_n = 1'b1;
    cyc(4);
    chk("rst_mid_refresh", bus.i2c_rdata, 8'h5A);
    chk("rst_mid_rq", rq.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
